mag_calc_seq: RTL and testbench

Parametrised, handshaked successor to the team's single-cycle vector-magnitude block. It computes round-or-floor of sqrt(x² + y²) for unsigned W-bit operands using a registered square-and-sum stage followed by a bit-serial digit-by-digit integer square root, producing one result bit per cycle. It sits between an upstream operand source and a downstream consumer, both connected through valid/ready handshakes. The exact root has no Newton-iteration error.

---
 rtl/mag_calc_seq_if.sv | 27 ++
 rtl/mag_calc_seq.sv | 124 ++++++++++++
 tb/tb_mag_calc_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mag_calc_seq_if.sv
// Operand/result handshake bundle for mag_calc_seq.
// master = operand source and result consumer; slave = the magnitude engine.
interface mag_calc_seq_if #(
  parameter int W = 8
);
  // Both channels use strict valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; a raised valid and its payload are
  // held until that edge, and ready never depends on valid in the same cycle.
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic         round_in;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_mag;

  modport master (
    output in_valid, x_in, y_in, round_in, out_ready,
    input  in_ready, out_valid, out_mag
  );

  modport slave (
    input  in_valid, x_in, y_in, round_in, out_ready,
    output in_ready, out_valid, out_mag
  );
endinterface

// File: rtl/mag_calc_seq.sv
// Sequential vector magnitude: floor or round of sqrt(x^2 + y^2), computed by a
// registered square-and-sum followed by a one-bit-per-cycle digit-by-digit root.
module mag_calc_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  mag_calc_seq_if.slave  bus,
  output logic           busy,
  output logic [1:0]     dbg_state_o
);

  localparam int SW  = 2 * W + 2;
  localparam int RMW = W + 2;
  localparam int CW  = $clog2(W + 1);
  localparam logic [W:0] MAG_ONE = {{W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    ROOT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic           rnd_q, rnd_d;
  logic [SW-1:0]  s_q, s_d;
  logic [RMW-1:0] rem_q, rem_d;
  logic [W:0]     root_q, root_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     mag_q, mag_d;

  logic [2*W-1:0] sq_x, sq_y;
  logic [RMW+1:0] rem_sh;
  logic [W+2:0]   trial;

  assign sq_x   = {{W{1'b0}}, x_q} * {{W{1'b0}}, x_q};
  assign sq_y   = {{W{1'b0}}, y_q} * {{W{1'b0}}, y_q};
  assign rem_sh = {rem_q, s_q[SW-1:SW-2]};
  assign trial  = {root_q, 2'b01};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      rnd_q   <= 1'b0;
      s_q     <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          rnd_d   = bus.round_in;
          state_d = SUM;
        end
      end
      SUM: begin
        s_d     = {2'b00, sq_x} + {2'b00, sq_y};
        cnt_d   = CW'(W);
        rem_d   = '0;
        root_d  = '0;
        state_d = ROOT;
      end
      ROOT: begin
        s_d = {s_q[SW-3:0], 2'b00};
        if (rem_sh >= {1'b0, trial}) begin
          rem_d  = RMW'(rem_sh - {1'b0, trial});
          root_d = {root_q[W-1:0], 1'b1};
        end else begin
          rem_d  = RMW'(rem_sh);
          root_d = {root_q[W-1:0], 1'b0};
        end
        if (cnt_q == '0) begin
          // remainder > root means sqrt(s) >= root + 0.5, so round up
          mag_d   = (rnd_q && (rem_d > {1'b0, root_d})) ? root_d + MAG_ONE : root_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_mag   = mag_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mag_calc_seq.sv
// Directed vector table, multi-cycle corner sequences and a random scoreboard
// run for mag_calc_seq at W=8 and W=12.
module tb_mag_calc_seq;

  logic clk;
  logic rst;
  logic busy8, busy12;
  logic [1:0] st8, st12;
  int cyc;
  int n_pass;
  int n_tot;

  mag_calc_seq_if #(.W(8))  if8  ();
  mag_calc_seq_if #(.W(12)) if12 ();

  mag_calc_seq #(.W(8)) u8 (
    .clk(clk), .rst(rst), .bus(if8), .busy(busy8), .dbg_state_o(st8)
  );

  mag_calc_seq #(.W(12)) u12 (
    .clk(clk), .rst(rst), .bus(if12), .busy(busy12), .dbg_state_o(st12)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    bit         r;
    int         exp;
  } vec_t;

  vec_t vecs[11];

  localparam int N_RND = 1000;
  logic [8:0]  exp8_q[$];
  logic [12:0] exp12_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: exhaustive integer sqrt, rounding decided by 4s vs (2q+1)^2.
  function automatic int ref_mag(input int x, input int y, input bit r);
    longint s, q;
    s = longint'(x) * x + longint'(y) * y;
    q = 0;
    while ((q + 1) * (q + 1) <= s) q++;
    if (r && (4 * s > (2 * q + 1) * (2 * q + 1))) q++;
    return int'(q);
  endfunction

  // Driver: present one pair on the W=8 port, scramble inputs while busy,
  // and report result, latency in edges after acceptance, and acceptance cycle.
  task automatic apply8(input logic [7:0] x, input logic [7:0] y, input bit r,
                        input bit release_out, output int mag, output int lat,
                        output int e0cyc);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!if8.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if8.in_valid = 1'b1;
    if8.x_in     = x;
    if8.y_in     = y;
    if8.round_in = r;
    @(posedge clk);
    #1;
    e0cyc = cyc;
    lat   = 0;
    if8.in_valid = 1'b0;
    while (!if8.out_valid && lat < 100) begin
      if8.x_in     = 8'($urandom);
      if8.y_in     = 8'($urandom);
      if8.round_in = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    mag = int'(if8.out_mag);
    if (release_out) begin
      @(negedge clk);
      if8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      if8.out_ready = 1'b0;
    end
  endtask

  initial begin
    int mag, lat, e0, prev_e0, rel, bad, guard;
    int sent8, got8, sent12, got12;
    logic [7:0]  rx8, ry8;
    logic [11:0] rx12, ry12;
    bit rr;

    n_pass = 0;
    n_tot  = 0;
    rst = 1'b1;
    if8.in_valid  = 1'b0; if8.x_in  = '0; if8.y_in  = '0; if8.round_in  = 1'b0; if8.out_ready  = 1'b0;
    if12.in_valid = 1'b0; if12.x_in = '0; if12.y_in = '0; if12.round_in = 1'b0; if12.out_ready = 1'b0;

    vecs[0]  = '{8'd3,   8'd4,   1'b0, 5};
    vecs[1]  = '{8'd2,   8'd3,   1'b0, 3};
    vecs[2]  = '{8'd2,   8'd3,   1'b1, 4};
    vecs[3]  = '{8'd6,   8'd7,   1'b0, 9};
    vecs[4]  = '{8'd6,   8'd7,   1'b1, 9};
    vecs[5]  = '{8'd0,   8'd0,   1'b0, 0};
    vecs[6]  = '{8'd0,   8'd0,   1'b1, 0};
    vecs[7]  = '{8'd255, 8'd255, 1'b0, 360};
    vecs[8]  = '{8'd255, 8'd255, 1'b1, 361};
    vecs[9]  = '{8'd255, 8'd0,   1'b0, 255};
    vecs[10] = '{8'd255, 8'd0,   1'b1, 255};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(if8.out_valid), 0);
    chk("rst_out_mag",   int'(if8.out_mag),   0);
    chk("rst_busy",      int'(busy8),         0);
    chk("rst_in_ready",  int'(if8.in_ready),  1);

    // directed table, out_ready raised as soon as the result appears
    prev_e0 = 0;
    for (int i = 0; i < 11; i++) begin
      apply8(vecs[i].x, vecs[i].y, vecs[i].r, 1'b1, mag, lat, e0);
      chk($sformatf("vec%0d_mag", i), mag, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, 10);
      if (i > 0) chk($sformatf("vec%0d_period", i), e0 - prev_e0, 12);
      prev_e0 = e0;
    end

    // backpressure: result held 20 cycles while a competing pair is offered
    apply8(8'd5, 8'd12, 1'b0, 1'b0, mag, lat, e0);
    chk("bp_mag", mag, 13);
    chk("bp_latency", lat, 10);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if8.in_valid = 1'b1;
      if8.x_in     = 8'($urandom);
      if8.y_in     = 8'($urandom);
      if (!(if8.out_valid && if8.out_mag == 9'd13 && !if8.in_ready)) bad++;
    end
    chk("bp_hold_bad_cycles", bad, 0);
    if8.in_valid = 1'b0;
    @(negedge clk);
    if8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rel = cyc;
    if8.out_ready = 1'b0;
    chk("bp_release_in_ready", int'(if8.in_ready), 1);
    chk("bp_release_out_valid", int'(if8.out_valid), 0);
    apply8(8'd1, 8'd1, 1'b0, 1'b1, mag, lat, e0);
    chk("bp_next_accept_gap", e0 - rel, 1);
    chk("bp_next_mag", mag, 1);

    // reset during the 4th ROOT cycle
    @(negedge clk);
    if8.in_valid = 1'b1;
    if8.x_in     = 8'd200;
    if8.y_in     = 8'd100;
    if8.round_in = 1'b1;
    @(posedge clk);
    #1;
    if8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_root_state", int'(st8), 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(if8.out_valid), 0);
    chk("mid_rst_busy", int'(busy8), 0);
    chk("mid_rst_in_ready", int'(if8.in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (if8.out_valid || busy8) bad++;
    end
    chk("post_rst_spurious", bad, 0);
    apply8(8'd8, 8'd15, 1'b0, 1'b1, mag, lat, e0);
    chk("post_rst_mag", mag, 17);

    // random scoreboard run on both widths, random out_ready
    sent8 = 0; got8 = 0; sent12 = 0; got12 = 0; guard = 0;
    while ((got8 < N_RND || got12 < N_RND) && guard < 60000) begin
      @(negedge clk);
      guard++;
      if (if8.out_valid) begin
        if8.out_ready = ($urandom_range(0, 3) != 0);
        if (if8.out_ready) begin
          if (exp8_q.size() == 0) chk("rnd8_unexpected", 1, 0);
          else begin
            chk("rnd8_mag", int'(if8.out_mag), int'(exp8_q.pop_front()));
            got8++;
          end
        end
      end else if8.out_ready = 1'($urandom_range(0, 1));
      if (if8.in_ready && sent8 < N_RND) begin
        rx8 = 8'($urandom_range(0, 255));
        ry8 = 8'($urandom_range(0, 255));
        rr  = 1'($urandom_range(0, 1));
        if8.in_valid = 1'b1; if8.x_in = rx8; if8.y_in = ry8; if8.round_in = rr;
        exp8_q.push_back(9'(ref_mag(int'(rx8), int'(ry8), rr)));
        sent8++;
      end else begin
        if8.in_valid = !if8.in_ready && ($urandom_range(0, 1) == 1);
        if8.x_in = 8'($urandom); if8.y_in = 8'($urandom); if8.round_in = 1'($urandom);
      end

      if (if12.out_valid) begin
        if12.out_ready = ($urandom_range(0, 3) != 0);
        if (if12.out_ready) begin
          if (exp12_q.size() == 0) chk("rnd12_unexpected", 1, 0);
          else begin
            chk("rnd12_mag", int'(if12.out_mag), int'(exp12_q.pop_front()));
            got12++;
          end
        end
      end else if12.out_ready = 1'($urandom_range(0, 1));
      if (if12.in_ready && sent12 < N_RND) begin
        rx12 = 12'($urandom_range(0, 4095));
        ry12 = 12'($urandom_range(0, 4095));
        rr   = 1'($urandom_range(0, 1));
        if12.in_valid = 1'b1; if12.x_in = rx12; if12.y_in = ry12; if12.round_in = rr;
        exp12_q.push_back(13'(ref_mag(int'(rx12), int'(ry12), rr)));
        sent12++;
      end else begin
        if12.in_valid = !if12.in_ready && ($urandom_range(0, 1) == 1);
        if12.x_in = 12'($urandom); if12.y_in = 12'($urandom); if12.round_in = 1'($urandom);
      end
    end
    if8.in_valid = 1'b0;  if8.out_ready = 1'b0;
    if12.in_valid = 1'b0; if12.out_ready = 1'b0;
    chk("rnd8_count", got8, N_RND);
    chk("rnd12_count", got12, N_RND);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
